issue_sched: RTL and testbench

Issue scheduler in front of the scoreboard. Each cycle it picks at most one of the two reservation-station heads to issue: pip0 is the 1-cycle ex pipe and pip1 is the 4-cycle mul pipe. It drives the scoreboard order select and pops the winning station. It tracks scoreboard occupancy and a write-back slot reservation vector, so that a grant never overfills the scoreboard and never collides with another instruction's write-back cycle.

---
 rtl/issue_sched.sv | 143 ++++++++++++++
 tb/tb_issue_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/issue_sched.sv
// Issue scheduler: grants at most one of the ex/mul station heads per cycle (0-cycle grant, state moves on next edge).
// Grants are withheld when the scoreboard is full or the pipe's write-back slot is already booked; flush drops all bookings.
module issue_sched #(
  parameter int                    W_PA_REG   = 5,
  parameter int                    W_PD_UOPS  = 6,
  parameter logic [W_PD_UOPS-1:0]  unused_op  = {W_PD_UOPS{1'b1}},
  parameter int                    S_amt_cell = 8,
  parameter int                    S_amt_ex   = 1,
  parameter int                    S_amt_mul  = 4,
  parameter int                    W_occ      = 4,
  parameter int                    W_stcnt    = 8
) (
  input  logic                 clk,
  input  logic                 CFI_PC_rst,
  input  logic [W_PD_UOPS-1:0] CDI_PD_uops0,
  input  logic [W_PD_UOPS-1:0] CDI_PD_uops1,
  input  logic                 CFI_PC_clear,
  input  logic                 CDI_PC_wbdone,
  output logic [1:0]           CDO_PC_odr,
  output logic                 CDO_PC_gnt0,
  output logic                 CDO_PC_gnt1,
  output logic                 CDO_PC_stall,
  output logic [W_occ-1:0]     CDO_PD_occ,
  output logic [W_stcnt-1:0]   CDO_PD_stcnt
);

  generate
    if (W_PA_REG < 1) begin : g_bad_reg
      $error("issue_sched: W_PA_REG must be positive");
    end
    if (S_amt_mul <= S_amt_ex || S_amt_ex < 1) begin : g_bad_lat
      $error("issue_sched: need 1 <= S_amt_ex < S_amt_mul");
    end
    if ((1 << W_occ) <= S_amt_cell) begin : g_bad_occ
      $error("issue_sched: W_occ too narrow for S_amt_cell");
    end
  endgenerate

  typedef enum logic {
    FAV_EX  = 1'b0,
    FAV_MUL = 1'b1
  } prio_e;

  logic [W_occ-1:0]     occ, occ_nxt;
  logic [S_amt_mul-1:0] wbres, wbres_nxt;
  prio_e                prio, prio_nxt;
  logic [W_stcnt-1:0]   stcnt;

  logic req0, req1, space, flush;
  logic slot_free_ex, slot_free_mul;
  logic elig0, elig1;
  logic gnt0, gnt1, stall;
  logic occ_inc, occ_dec;

  assign req0  = (CDI_PD_uops0 != unused_op);
  assign req1  = (CDI_PD_uops1 != unused_op);
  assign flush = CFI_PC_rst | CFI_PC_clear;

  // a retiring cell is reusable in the same cycle
  assign space = (occ < W_occ'(S_amt_cell)) | CDI_PC_wbdone;

  // a latency beyond the booking window can never collide
  generate
    if (S_amt_ex < S_amt_mul) begin : g_ex_slot
      assign slot_free_ex = ~wbres[S_amt_ex];
    end else begin : g_ex_free
      assign slot_free_ex = 1'b1;
    end
  endgenerate
  assign slot_free_mul = 1'b1;

  assign elig0 = req0 & space & slot_free_ex;
  assign elig1 = req1 & space & slot_free_mul;

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    prio_nxt = prio;
    if (!flush) begin
      if (elig0 && elig1) begin
        if (prio == FAV_EX) begin
          gnt0     = 1'b1;
          prio_nxt = FAV_MUL;
        end else begin
          gnt1     = 1'b1;
          prio_nxt = FAV_EX;
        end
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
  end

  assign stall = (req0 | req1) & ~gnt0 & ~gnt1 & ~flush;

  always_comb begin
    wbres_nxt = wbres >> 1;
    if (gnt0) wbres_nxt[S_amt_ex-1]  = 1'b1;
    if (gnt1) wbres_nxt[S_amt_mul-1] = 1'b1;
  end

  assign occ_inc = gnt0 | gnt1;
  assign occ_dec = CDI_PC_wbdone & (occ != '0);

  always_comb begin
    occ_nxt = occ;
    if (occ_inc && !occ_dec) begin
      occ_nxt = occ + W_occ'(1);
    end else if (!occ_inc && occ_dec) begin
      occ_nxt = occ - W_occ'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      occ   <= '0;
      wbres <= '0;
      prio  <= FAV_EX;
    end else begin
      occ   <= occ_nxt;
      wbres <= wbres_nxt;
      prio  <= prio_nxt;
    end
  end

  // the stall counter survives a clear; only reset zeroes it
  always_ff @(posedge clk) begin
    if (CFI_PC_rst) begin
      stcnt <= '0;
    end else if (stall && (stcnt != '1)) begin
      stcnt <= stcnt + W_stcnt'(1);
    end
  end

  assign CDO_PC_gnt0  = gnt0;
  assign CDO_PC_gnt1  = gnt1;
  assign CDO_PC_odr   = {gnt1, gnt0};
  assign CDO_PC_stall = stall;
  assign CDO_PD_occ   = occ;
  assign CDO_PD_stcnt = stcnt;

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_issue_sched;

  localparam logic [5:0] U = 6'h3F;
  localparam logic [5:0] A = 6'h05;
  localparam logic [5:0] B = 6'h2A;

  logic       clk;
  logic       rst;
  logic [5:0] uops0;
  logic [5:0] uops1;
  logic       clear;
  logic       wbdone;
  logic [1:0] odr;
  logic       gnt0;
  logic       gnt1;
  logic       stall;
  logic [3:0] occ;
  logic [7:0] stcnt;

  issue_sched dut (
    .clk           (clk),
    .CFI_PC_rst    (rst),
    .CDI_PD_uops0  (uops0),
    .CDI_PD_uops1  (uops1),
    .CFI_PC_clear  (clear),
    .CDI_PC_wbdone (wbdone),
    .CDO_PC_odr    (odr),
    .CDO_PC_gnt0   (gnt0),
    .CDO_PC_gnt1   (gnt1),
    .CDO_PC_stall  (stall),
    .CDO_PD_occ    (occ),
    .CDO_PD_stcnt  (stcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] odr;
    logic       stall;
    int         occ;
    int         stcnt;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  task automatic check(input string name, input int id, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %0d required %0d", name, id, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("odr",   e.id, int'(odr),   int'(e.odr));
      check("gnt0",  e.id, int'(gnt0),  int'(e.odr[0]));
      check("gnt1",  e.id, int'(gnt1),  int'(e.odr[1]));
      check("stall", e.id, int'(stall), int'(e.stall));
      check("occ",   e.id, int'(occ),   e.occ);
      check("stcnt", e.id, int'(stcnt), e.stcnt);
    end
  end

  // one cycle: drive inputs just after the edge, expect outputs within that cycle
  task automatic step(input logic r, input logic c, input logic [5:0] u0, input logic [5:0] u1,
                      input logic w, input logic [1:0] e_odr, input logic e_stall,
                      input int e_occ, input int e_stcnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    clear  = c;
    uops0  = u0;
    uops1  = u1;
    wbdone = w;
    e.odr   = e_odr;
    e.stall = e_stall;
    e.occ   = e_occ;
    e.stcnt = e_stcnt;
    e.id    = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  logic [1:0] mix_odr [5];

  initial begin
    rst    = 1'b1;
    clear  = 1'b0;
    uops0  = A;
    uops1  = B;
    wbdone = 1'b0;
    mix_odr = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};

    // reset held with both requests valid, then first grant right after release
    step(1, 0, A, B, 0, 2'b00, 0, 0, 0);
    step(1, 0, A, B, 0, 2'b00, 0, 0, 0);
    step(0, 0, A, B, 0, 2'b01, 0, 0, 0);
    step(1, 0, U, U, 0, 2'b00, 0, 1, 0);

    // back-to-back ex with a retire every cycle
    for (int i = 0; i < 5; i++) step(0, 0, A, U, 1, 2'b01, 0, (i == 0) ? 0 : 1, 0);
    step(1, 0, U, U, 0, 2'b00, 0, 1, 0);

    // mixed stream: ex blocked at t4 by the mul booking from t1
    for (int i = 0; i < 5; i++) step(0, 0, A, B, 0, mix_odr[i], 0, i, 0);
    step(1, 0, U, U, 0, 2'b00, 0, 5, 0);

    // retire with empty scoreboard is ignored
    step(0, 0, U, U, 1, 2'b00, 0, 0, 0);
    step(0, 0, U, U, 1, 2'b00, 0, 0, 0);

    // fill the scoreboard
    for (int i = 0; i < 8; i++) step(0, 0, A, U, 0, 2'b01, 0, i, 0);
    step(0, 0, A, U, 0, 2'b00, 1, 8, 0);
    step(0, 0, A, U, 0, 2'b00, 1, 8, 1);
    step(0, 0, A, U, 1, 2'b01, 0, 8, 2);
    step(0, 0, U, U, 0, 2'b00, 0, 8, 2);

    // long stall run saturates the counter
    for (int k = 0; k < 300; k++) step(0, 0, A, U, 0, 2'b00, 1, 8, ((2 + k) > 255) ? 255 : (2 + k));
    step(0, 0, U, U, 0, 2'b00, 0, 8, 255);

    // clear empties the scoreboard but keeps the stall count
    step(0, 1, A, B, 0, 2'b00, 0, 8, 255);
    step(0, 0, U, U, 0, 2'b00, 0, 0, 255);
    step(1, 0, U, U, 0, 2'b00, 0, 0, 255);

    // flush after a mul grant: ex at t3 would collide if the booking survived
    step(0, 0, U, B, 0, 2'b10, 0, 0, 0);
    step(0, 1, A, B, 0, 2'b00, 0, 1, 0);
    step(0, 0, A, U, 0, 2'b01, 0, 0, 0);
    step(0, 0, A, U, 0, 2'b01, 0, 1, 0);
    step(0, 0, U, U, 0, 2'b00, 0, 2, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
